touch_cmd_tx: RTL and testbench
===============================

# touch_cmd_tx

Serial master for the resistive-touch ADC link. On request, it asserts chip-select and generates the 24-period serial clock `touch_clk`. It shifts an 8-bit control byte out MSB-first on `touch_din`, then drives the 12-bit read window. During that window it asserts `rx_ena` so that the 12-bit shift-in receiver captures exactly 12 bits on 12 consecutive `touch_clk` rising edges.

## Interface
- `CLK_DIV`, default 50: `touch_clk` half-period in `clk` cycles. Legal range 1..255. Must be ≥2 when driving the edge-detecting receiver.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: frame request; sampled only when `ready`=1.
- `cmd` in 8: control byte; latched on the cycle `start` is accepted.
- `ready` out 1: idle, can accept `start`.
- `touch_cs_n` out 1: ADC chip-select, active-low.
- `touch_clk` out 1: serial clock to the ADC and the receiver; registered.
- `touch_din` out 1: serial command data to the ADC; registered.
- `rx_ena` out 1: receiver enable window covering rising edges 10..21.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- States: IDLE, LEAD, HIGH, LOW, TAIL, DONE.
- Counters:
  - `div_cnt` (8 bit) counts 0..CLK_DIV-1 within every phase.
  - `edge_cnt` (5 bit) counts rising edges 1..24.
- IDLE outputs: `ready`=1, `touch_cs_n`=1, `touch_clk`=0, `touch_din`=0, `rx_ena`=0, `done`=0.
- IDLE with `start`=1: latch `cmd` into the shift register, go to LEAD. Next cycle: `touch_cs_n`=0, `touch_din`=`cmd[7]`, `ready`=0.
- LEAD: CLK_DIV cycles with `touch_clk`=0. Then `touch_clk`←1 (rising edge 1), go to HIGH.
- HIGH: CLK_DIV cycles. Then `touch_clk`←0 (falling edge k), go to LOW, or to TAIL if k=24.
- LOW: CLK_DIV cycles. Then `touch_clk`←1, go to HIGH.
- `touch_din` changes only at falling edges:
  - Falling edges 1..7 present `cmd[6]..cmd[0]`.
  - Falling edge 8 onward drives 0.
  - `touch_din` is therefore stable across every rising edge.
- `rx_ena` rises in the same cycle as falling edge 9 (after the busy period) and falls in the same cycle as falling edge 21. Rising edges 10..21, exactly 12, fall inside the window.
- TAIL: CLK_DIV cycles, `touch_cs_n`=0, `touch_clk`=0. Then go to DONE.
- DONE, one cycle: `touch_cs_n`=1, `done`=1, `ready`=0. Then go to IDLE.
- The minimum `touch_cs_n` high time between frames is 2 cycles: DONE plus the IDLE cycle that accepts `start`.
- `start` while `ready`=0 is ignored. `cmd` changes after acceptance have no effect.
- Reset low in any state: on the next edge all outputs take their IDLE values, counters clear, and the shift register clears. A partial frame is abandoned and there is no `done` pulse.

## Timing
- T0 = cycle in which `start` is sampled high in IDLE.
- T0+1: `touch_cs_n`=0, `touch_din`=`cmd[7]`.
- Rising edge k (k=1..24) is at T0+1+CLK_DIV+(k-1)·2·CLK_DIV.
- Falling edge k is at rising edge k + CLK_DIV.
- Falling edge 24 is at T0+1+48·CLK_DIV.
- DONE: `done`=1 and `touch_cs_n`=1 at T0+1+49·CLK_DIV.
- IDLE: `ready`=1 at T0+2+49·CLK_DIV.
- Frame length, `start` to next `ready`, is 49·CLK_DIV+2 cycles.
- `touch_clk` duty is exactly 50%, period 2·CLK_DIV.
- CLK_DIV=1 gives a 2-cycle `touch_clk` period. This is legal, but the receiver's one-cycle edge detect lag makes capture invalid at this setting.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `start`=1. Required: `touch_cs_n`=1, `touch_clk`=0, `touch_din`=0, `rx_ena`=0, `done`=0, `ready`=1 after release.
- Single frame, CLK_DIV=2, `cmd`=0x93:
  - `touch_cs_n` falls at T0+1.
  - Bits sampled on rising edges 1..8 read 1,0,0,1,0,0,1,1; `touch_din`=0 thereafter.
  - 24 rising edges total.
  - `done` at T0+99; `ready` at T0+100.
- Receiver window: connect the shift-in receiver, with a model ADC returning 0xA5C on edges 10..21. Required: receiver `data_out`=0xA5C, and exactly 12 `touch_clk` rising edges counted while `rx_ena`=1.
- Back-to-back frames:
  - `start` held high continuously with `cmd` 0xD0 then 0x90. Two frames run; `touch_cs_n` stays high for exactly 2 cycles between them.
  - `cmd` changed mid-frame does not alter `touch_din`.
- Reset mid-frame: `rst`=0 at rising edge 12. Required:
  - Next cycle: `touch_cs_n`=1, `rx_ena`=0, `touch_clk`=0.
  - No `done` pulse.
  - A new frame after release completes normally.
- CLK_DIV=1 and CLK_DIV=255 builds: edge timing matches the Timing formulas exactly, and the `touch_clk` high and low phase lengths each equal CLK_DIV.

Source files
------------

// File: rtl/touch_cmd_tx.sv
// touch_cmd_tx: serial command master for the resistive-touch ADC link.
// It frames one conversion with chip-select and generates 24 touch_clk periods.
// The 8-bit control byte goes out MSB-first on touch_din, changing only on falling edges.
// rx_ena brackets rising edges 10..21 so the shift-in receiver captures 12 bits.
// Every output comes straight from a register.
module touch_cmd_tx #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd,
  output logic       ready,
  output logic       touch_cs_n,
  output logic       touch_clk,
  output logic       touch_din,
  output logic       rx_ena,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    TAIL = 3'd4,
    DONE = 3'd5
  } state_t;

  // Last div_cnt value of a phase; each phase lasts CLK_DIV cycles.
  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] EDGE_LAST = 5'd24;
  // rx_ena opens on falling edge 9 and closes on falling edge 21.
  localparam logic [4:0] RX_OPEN   = 5'd9;
  localparam logic [4:0] RX_CLOSE  = 5'd21;

  state_t     state_r, state_s;
  logic [7:0] div_cnt_r, div_cnt_s;
  logic [4:0] edge_cnt_r, edge_cnt_s;
  logic [7:0] shift_r, shift_s;
  logic       ready_r, ready_s;
  logic       cs_n_r, cs_n_s;
  logic       clk_r, clk_s;
  logic       din_r, din_s;
  logic       rx_ena_r, rx_ena_s;
  logic       done_r, done_s;
  logic       phase_end_s;

  assign phase_end_s = (div_cnt_r == DIV_LAST);

  assign ready      = ready_r;
  assign touch_cs_n = cs_n_r;
  assign touch_clk  = clk_r;
  assign touch_din  = din_r;
  assign rx_ena     = rx_ena_r;
  assign done       = done_r;

  // Next-state and next-output logic; every register holds unless its state says otherwise.
  always_comb begin
    state_s    = state_r;
    div_cnt_s  = div_cnt_r;
    edge_cnt_s = edge_cnt_r;
    shift_s    = shift_r;
    ready_s    = ready_r;
    cs_n_s     = cs_n_r;
    clk_s      = clk_r;
    din_s      = din_r;
    rx_ena_s   = rx_ena_r;
    done_s     = done_r;

    case (state_r)
      IDLE: begin
        div_cnt_s  = 8'd0;
        edge_cnt_s = 5'd0;
        clk_s      = 1'b0;
        rx_ena_s   = 1'b0;
        done_s     = 1'b0;
        if (start) begin
          // The MSB goes out with chip-select; the rest waits in the shift register.
          state_s = LEAD;
          shift_s = cmd;
          ready_s = 1'b0;
          cs_n_s  = 1'b0;
          din_s   = cmd[7];
        end else begin
          state_s = IDLE;
          ready_s = 1'b1;
          cs_n_s  = 1'b1;
          din_s   = 1'b0;
        end
      end

      LEAD: begin
        ready_s = 1'b0;
        cs_n_s  = 1'b0;
        done_s  = 1'b0;
        if (phase_end_s) begin
          div_cnt_s  = 8'd0;
          clk_s      = 1'b1;
          edge_cnt_s = edge_cnt_r + 5'd1;
          state_s    = HIGH;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      HIGH: begin
        if (phase_end_s) begin
          // Falling edge k (k = edge_cnt_r): data and the receive window move only here.
          // The shift register fills with zeros, so edges 8 onward drive 0.
          div_cnt_s = 8'd0;
          clk_s     = 1'b0;
          din_s     = shift_r[6];
          shift_s   = {shift_r[6:0], 1'b0};
          rx_ena_s  = (edge_cnt_r >= RX_OPEN) && (edge_cnt_r < RX_CLOSE);
          if (edge_cnt_r == EDGE_LAST) begin
            state_s = TAIL;
          end else begin
            state_s = LOW;
          end
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      LOW: begin
        if (phase_end_s) begin
          div_cnt_s  = 8'd0;
          clk_s      = 1'b1;
          edge_cnt_s = edge_cnt_r + 5'd1;
          state_s    = HIGH;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      TAIL: begin
        if (phase_end_s) begin
          div_cnt_s = 8'd0;
          cs_n_s    = 1'b1;
          done_s    = 1'b1;
          state_s   = DONE;
        end else begin
          div_cnt_s = div_cnt_r + 8'd1;
        end
      end

      DONE: begin
        state_s    = IDLE;
        done_s     = 1'b0;
        ready_s    = 1'b1;
        cs_n_s     = 1'b1;
        edge_cnt_s = 5'd0;
        shift_s    = 8'd0;
      end

      default: begin
        state_s    = IDLE;
        div_cnt_s  = 8'd0;
        edge_cnt_s = 5'd0;
        shift_s    = 8'd0;
        ready_s    = 1'b1;
        cs_n_s     = 1'b1;
        clk_s      = 1'b0;
        din_s      = 1'b0;
        rx_ena_s   = 1'b0;
        done_s     = 1'b0;
      end
    endcase
  end

  // State, counters, shift register and output registers; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      edge_cnt_r <= 5'd0;
      shift_r    <= 8'd0;
      ready_r    <= 1'b1;
      cs_n_r     <= 1'b1;
      clk_r      <= 1'b0;
      din_r      <= 1'b0;
      rx_ena_r   <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      div_cnt_r  <= div_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      shift_r    <= shift_s;
      ready_r    <= ready_s;
      cs_n_r     <= cs_n_s;
      clk_r      <= clk_s;
      din_r      <= din_s;
      rx_ena_r   <= rx_ena_s;
      done_r     <= done_s;
    end
  end

endmodule

// File: tb/tb_touch_cmd_tx.sv
// tb_touch_cmd_tx: directed bench for touch_cmd_tx at CLK_DIV = 2, 1 and 255.
// A model ADC and an edge-detecting shift-in receiver hang off the CLK_DIV=2 instance.
module tb_touch_cmd_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_a;
  logic [2:0] ready_a, cs_a, tclk_a, din_a, rxe_a, done_a;
  logic [7:0] cmd_a [3];

  int checks = 0;
  int errors = 0;

  touch_cmd_tx #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .start(start_a[0]), .cmd(cmd_a[0]), .ready(ready_a[0]),
    .touch_cs_n(cs_a[0]), .touch_clk(tclk_a[0]), .touch_din(din_a[0]),
    .rx_ena(rxe_a[0]), .done(done_a[0])
  );

  touch_cmd_tx #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .cmd(cmd_a[1]), .ready(ready_a[1]),
    .touch_cs_n(cs_a[1]), .touch_clk(tclk_a[1]), .touch_din(din_a[1]),
    .rx_ena(rxe_a[1]), .done(done_a[1])
  );

  touch_cmd_tx #(.CLK_DIV(255)) u_div255 (
    .clk(clk), .rst(rst), .start(start_a[2]), .cmd(cmd_a[2]), .ready(ready_a[2]),
    .touch_cs_n(cs_a[2]), .touch_clk(tclk_a[2]), .touch_din(din_a[2]),
    .rx_ena(rxe_a[2]), .done(done_a[2])
  );

  // Cycle numbering: after the posedge that accepts start (T0), pc reads T0+1.
  int pc = 0;
  int t0 [3] = '{0, 0, 0};

  // Cycle counter and start-acceptance time stamps.
  always @(posedge clk) begin
    pc <= pc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst && start_a[d] && ready_a[d]) t0[d] <= pc;
    end
  end

  // Event monitor: time-stamps edges, done, ready and chip-select transitions.
  int          rise_n [3] = '{0, 0, 0};
  int          fall_n [3] = '{0, 0, 0};
  int          done_n [3] = '{0, 0, 0};
  int          ready_n [3] = '{0, 0, 0};
  int          rx_rise [3] = '{0, 0, 0};
  int          rise_cyc [3][128];
  int          fall_cyc [3][128];
  int          done_cyc [3];
  int          ready_cyc [3];
  int          csf_cyc [3];
  int          csr_cyc [3];
  int          cs_gap [3];
  logic [47:0] bits [3] = '{48'd0, 48'd0, 48'd0};
  logic [2:0]  p_tclk = 3'b000;
  logic [2:0]  p_ready = 3'b000;
  logic [2:0]  p_cs = 3'b111;

  // Monitor process, sampled on the falling clk edge away from output changes.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (tclk_a[d] && !p_tclk[d]) begin
        if (rise_n[d] < 128) rise_cyc[d][rise_n[d]] <= pc;
        rise_n[d] <= rise_n[d] + 1;
        bits[d]   <= {bits[d][46:0], din_a[d]};
        if (rxe_a[d]) rx_rise[d] <= rx_rise[d] + 1;
      end
      if (!tclk_a[d] && p_tclk[d]) begin
        if (fall_n[d] < 128) fall_cyc[d][fall_n[d]] <= pc;
        fall_n[d] <= fall_n[d] + 1;
      end
      if (done_a[d]) begin
        done_n[d]   <= done_n[d] + 1;
        done_cyc[d] <= pc;
      end
      if (ready_a[d] && !p_ready[d]) begin
        ready_n[d]   <= ready_n[d] + 1;
        ready_cyc[d] <= pc;
      end
      if (!cs_a[d] && p_cs[d]) begin
        csf_cyc[d] <= pc;
        cs_gap[d]  <= pc - csr_cyc[d];
      end
      if (cs_a[d] && !p_cs[d]) csr_cyc[d] <= pc;
    end
    p_tclk  <= tclk_a;
    p_ready <= ready_a;
    p_cs    <= cs_a;
  end

  // Model ADC: counts falling edges in the frame and returns 0xA5C MSB-first for rising edges 10..21.
  logic [11:0] adc_val = 12'hA5C;
  int          adc_k = 0;
  logic        adc_p = 1'b0;
  logic        adc_bit;

  // ADC falling-edge counter, cleared while chip-select is high.
  always @(posedge clk) begin
    adc_p <= tclk_a[0];
    if (cs_a[0]) adc_k <= 0;
    else if (!tclk_a[0] && adc_p) adc_k <= adc_k + 1;
  end

  // ADC output bit for the rising edge that follows falling edge adc_k.
  always_comb begin
    adc_bit = 1'b0;
    if (adc_k >= 9 && adc_k <= 20) adc_bit = adc_val[4'(20 - adc_k)];
  end

  // Shift-in receiver: detects touch_clk rising one cycle late and shifts while rx_ena is high.
  logic [11:0] rdata = 12'd0;
  logic        rx_p = 1'b0;

  // Receiver shift process.
  always @(posedge clk) begin
    rx_p <= tclk_a[0];
    if (tclk_a[0] && !rx_p && rxe_a[0]) rdata <= {rdata[10:0], adc_bit};
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int b_rise, b_fall, b_done, b_ready, b_rx;

  task automatic snap(input int d);
    b_rise  = rise_n[d];
    b_fall  = fall_n[d];
    b_done  = done_n[d];
    b_ready = ready_n[d];
    b_rx    = rx_rise[d];
  endtask

  // Starts one frame on instance d and waits (bounded) for ready to return.
  task automatic frame(input int d, input logic [7:0] c, input int bound);
    snap(d);
    start_a[d] = 1'b1;
    cmd_a[d]   = c;
    step();
    start_a[d] = 1'b0;
    cmd_a[d]   = ~c;
    for (int i = 0; i < bound && ready_n[d] == b_ready; i++) step();
    chk("frame_completes", 32'(ready_n[d] != b_ready), 32'd1);
  endtask

  initial begin
    rst     = 1'b0;
    start_a = 3'b111;
    for (int d = 0; d < 3; d++) cmd_a[d] = 8'hFF;
    repeat (3) step();
    chk("rst_cs_n",  32'(cs_a[0]),    32'd1);
    chk("rst_clk",   32'(tclk_a[0]),  32'd0);
    chk("rst_din",   32'(din_a[0]),   32'd0);
    chk("rst_rx_ena", 32'(rxe_a[0]),  32'd0);
    chk("rst_done",  32'(done_a[0]),  32'd0);
    chk("rst_ready", 32'(ready_a[0]), 32'd1);
    rst     = 1'b1;
    start_a = 3'b000;
    step();
    chk("rel_ready", 32'(ready_a[0]), 32'd1);
    chk("rel_cs_n",  32'(cs_a[0]),    32'd1);

    // Single frame, CLK_DIV=2, cmd 0x93, receiver attached.
    frame(0, 8'h93, 300);
    chk("f1_cs_fall",  csf_cyc[0] - t0[0], 32'd1);
    chk("f1_rise1",    rise_cyc[0][b_rise] - t0[0], 32'd3);
    chk48("f1_bits",   48'(bits[0][23:0]), 48'h930000);
    chk("f1_rises",    rise_n[0] - b_rise, 32'd24);
    chk("f1_falls",    fall_n[0] - b_fall, 32'd24);
    chk("f1_fall24",   fall_cyc[0][b_fall + 23] - t0[0], 32'd97);
    chk("f1_done",     done_cyc[0] - t0[0], 32'd99);
    chk("f1_done_len", done_n[0] - b_done, 32'd1);
    chk("f1_ready",    ready_cyc[0] - t0[0], 32'd100);
    chk("rx_rises",    rx_rise[0] - b_rx, 32'd12);
    chk("rx_data",     32'(rdata), 32'h0000_0A5C);

    // Back-to-back frames with start held high; cmd changes mid-frame.
    snap(0);
    start_a[0] = 1'b1;
    cmd_a[0]   = 8'hD0;
    step();
    cmd_a[0]   = 8'h90;
    for (int i = 0; i < 400 && (done_n[0] - b_done) < 2; i++) step();
    start_a[0] = 1'b0;
    chk("b2b_frames",  done_n[0] - b_done, 32'd2);
    chk("b2b_cs_gap",  cs_gap[0], 32'd2);
    chk("b2b_rises",   rise_n[0] - b_rise, 32'd48);
    chk48("b2b_bits",  bits[0], 48'hD00000_900000);
    chk("b2b_done2",   done_cyc[0] - t0[0], 32'd99);
    repeat (3) step();
    chk("b2b_ready",   32'(ready_a[0]), 32'd1);

    // Reset at rising edge 12, then a clean frame.
    snap(0);
    start_a[0] = 1'b1;
    cmd_a[0]   = 8'hA5;
    step();
    start_a[0] = 1'b0;
    for (int i = 0; i < 200 && (rise_n[0] - b_rise) < 12; i++) step();
    chk("mid_rise12",  rise_n[0] - b_rise, 32'd12);
    chk("mid_rx_on",   32'(rxe_a[0]), 32'd1);
    rst = 1'b0;
    step();
    chk("mid_cs_n",    32'(cs_a[0]),   32'd1);
    chk("mid_rx_ena",  32'(rxe_a[0]),  32'd0);
    chk("mid_clk",     32'(tclk_a[0]), 32'd0);
    rst = 1'b1;
    repeat (120) step();
    chk("mid_no_done", done_n[0] - b_done, 32'd0);
    frame(0, 8'h5A, 300);
    chk48("mid_new_bits", 48'(bits[0][23:0]), 48'h5A0000);
    chk("mid_new_rises",  rise_n[0] - b_rise, 32'd24);
    chk("mid_new_done",   done_cyc[0] - t0[0], 32'd99);

    // CLK_DIV=1 timing.
    frame(1, 8'h3C, 200);
    chk("d1_rise1",  rise_cyc[1][b_rise] - t0[1], 32'd2);
    chk("d1_rise24", rise_cyc[1][b_rise + 23] - t0[1], 32'd48);
    chk("d1_fall24", fall_cyc[1][b_fall + 23] - t0[1], 32'd49);
    chk("d1_high",   fall_cyc[1][b_fall] - rise_cyc[1][b_rise], 32'd1);
    chk("d1_low",    rise_cyc[1][b_rise + 1] - fall_cyc[1][b_fall], 32'd1);
    chk("d1_done",   done_cyc[1] - t0[1], 32'd50);
    chk("d1_ready",  ready_cyc[1] - t0[1], 32'd51);
    chk48("d1_bits", 48'(bits[1][23:0]), 48'h3C0000);

    // CLK_DIV=255 timing.
    frame(2, 8'hC3, 13000);
    chk("d255_rise1",  rise_cyc[2][b_rise] - t0[2], 32'd256);
    chk("d255_rise24", rise_cyc[2][b_rise + 23] - t0[2], 32'd11986);
    chk("d255_fall24", fall_cyc[2][b_fall + 23] - t0[2], 32'd12241);
    chk("d255_high",   fall_cyc[2][b_fall] - rise_cyc[2][b_rise], 32'd255);
    chk("d255_low",    rise_cyc[2][b_rise + 1] - fall_cyc[2][b_fall], 32'd255);
    chk("d255_done",   done_cyc[2] - t0[2], 32'd12496);
    chk("d255_ready",  ready_cyc[2] - t0[2], 32'd12497);
    chk("d255_rx",     rx_rise[2] - b_rx, 32'd12);
    chk48("d255_bits", 48'(bits[2][23:0]), 48'hC30000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
